// File: rtl/prog_truth_table_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_truth_table_if
// Description : Evaluation stream and serial table-load signals of
//               prog_truth_table, bundled with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_truth_table_if #(
    parameter int N_IN = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_vec;
    logic            out_valid;
    logic            out_ready;
    logic            out_bit;
    logic [N_IN-1:0] out_vec;
    logic            cfg_start;
    logic            cfg_abort;
    logic            cfg_valid;
    logic            cfg_ready;
    logic            cfg_bit;
    logic            cfg_busy;
    logic            cfg_done;

    modport master (
        output in_valid, in_vec, out_ready,
        output cfg_start, cfg_abort, cfg_valid, cfg_bit,
        input  in_ready, out_valid, out_bit, out_vec,
        input  cfg_ready, cfg_busy, cfg_done
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        input  cfg_start, cfg_abort, cfg_valid, cfg_bit,
        output in_ready, out_valid, out_bit, out_vec,
        output cfg_ready, cfg_busy, cfg_done
    );
endinterface
`default_nettype wire

// File: rtl/prog_truth_table.sv
`default_nettype none
// ============================================================================
// Module      : prog_truth_table
// Description : Runtime-programmable N_IN-input truth-table evaluator with a
//               serially loaded shadow table committed atomically.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_truth_table #(
    parameter int                      N_IN = 4,
    parameter logic [(1<<N_IN)-1:0]    INIT = 16'h6300
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    prog_truth_table_if.slave  bus
);
    localparam int              c_DEPTH = 1 << N_IN;
    localparam logic [N_IN:0]   c_LAST  = (N_IN+1)'(c_DEPTH - 1);

    localparam logic [1:0] c_RUN   = 2'd0;
    localparam logic [1:0] c_DRAIN = 2'd1;
    localparam logic [1:0] c_LOAD  = 2'd2;

    logic [1:0]         r_state;
    logic [c_DEPTH-1:0] r_table;
    logic [c_DEPTH-1:0] r_shadow;
    logic [N_IN:0]      r_cnt;
    logic               r_out_valid;
    logic               r_out_bit;
    logic [N_IN-1:0]    r_out_vec;
    logic               r_cfg_done;

    logic               w_out_free;
    logic               w_in_ready;
    logic               w_accept;
    logic [c_DEPTH-1:0] w_merged;

    assign w_out_free = !r_out_valid || bus.out_ready;
    // A start request blocks intake so the load never races a new result.
    assign w_in_ready = (r_state == c_RUN) && !bus.cfg_start && w_out_free;
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        w_merged = r_shadow;
        w_merged[r_cnt[N_IN-1:0]] = bus.cfg_bit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_RUN;
            r_table     <= INIT;
            r_shadow    <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_vec   <= '0;
            r_cfg_done  <= 1'b0;
        end else begin
            r_cfg_done <= 1'b0;

            if (w_accept) begin
                r_out_bit   <= r_table[bus.in_vec];
                r_out_vec   <= bus.in_vec;
                r_out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                c_RUN: begin
                    if (bus.cfg_start) begin
                        if (w_out_free) begin
                            r_state <= c_LOAD;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= c_DRAIN;
                        end
                    end
                end
                c_DRAIN: begin
                    if (bus.cfg_abort) begin
                        r_state  <= c_RUN;
                        r_shadow <= '0;
                        r_cnt    <= '0;
                    end else if (w_out_free) begin
                        r_state <= c_LOAD;
                        r_cnt   <= '0;
                    end
                end
                c_LOAD: begin
                    if (bus.cfg_abort) begin
                        r_state  <= c_RUN;
                        r_shadow <= '0;
                        r_cnt    <= '0;
                    end else if (bus.cfg_valid) begin
                        r_shadow[r_cnt[N_IN-1:0]] <= bus.cfg_bit;
                        r_cnt                     <= r_cnt + 1'b1;
                        // Final beat: commit with the last bit merged in.
                        if (r_cnt == c_LAST) begin
                            r_table    <= w_merged;
                            r_shadow   <= '0;
                            r_cnt      <= '0;
                            r_cfg_done <= 1'b1;
                            r_state    <= c_RUN;
                        end
                    end
                end
                default: r_state <= c_RUN;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_bit   = r_out_bit;
    assign bus.out_vec   = r_out_vec;
    assign bus.cfg_ready = (r_state == c_LOAD);
    assign bus.cfg_busy  = (r_state == c_LOAD);
    assign bus.cfg_done  = r_cfg_done;
endmodule
`default_nettype wire

// File: tb/tb_prog_truth_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_truth_table
// Description : Self-checking bench for prog_truth_table (N_IN=4 and N_IN=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_truth_table;
    localparam logic [15:0] c_INIT4 = 16'h6300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_truth_table_if #(.N_IN(4)) b4 ();
    prog_truth_table_if #(.N_IN(2)) b2 ();

    prog_truth_table #(.N_IN(4), .INIT(16'h6300)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    prog_truth_table #(.N_IN(2), .INIT(4'b0110))  dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: current function table plus pending-result scoreboard.
    logic [15:0] ref4 = c_INIT4;
    bit          q_bit[$];
    logic [3:0]  q_vec[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic stream4(input int n, input bit rnd);
        bit m_ready;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i == n) begin
                b4.in_valid = 1'b0; b4.out_ready = 1'b1; b4.cfg_abort = 1'b0;
            end else if (rnd) begin
                b4.in_valid  = ($urandom % 4) != 0;
                b4.in_vec    = 4'($urandom);
                b4.out_ready = ($urandom % 3) != 0;
                b4.cfg_abort = ($urandom % 5) == 0;
            end else begin
                b4.in_valid = 1'b1; b4.in_vec = 4'(i); b4.out_ready = 1'b1;
            end
            #1;
            m_ready = (q_bit.size() == 0) || b4.out_ready;
            chk("out_valid", b4.out_valid, q_bit.size() != 0);
            chk("in_ready", b4.in_ready, m_ready);
            if (q_bit.size() != 0) begin
                chk("out_bit", b4.out_bit, q_bit[0]);
                chk("out_vec", b4.out_vec, q_vec[0]);
                if (b4.out_ready) begin
                    void'(q_bit.pop_front());
                    void'(q_vec.pop_front());
                end
            end
            if (b4.in_valid && m_ready) begin
                q_bit.push_back(ref4[b4.in_vec]);
                q_vec.push_back(b4.in_vec);
            end
        end
        b4.cfg_abort = 1'b0;
    endtask

    // kind: 0 full load, 1 abort with no beat, 2 abort on a beat, 3 reset.
    task automatic load4(input logic [15:0] val, input int kind, input int at, input bit gaps);
        int idx = 0;
        int busy = 0;
        bit stop = 1'b0;
        @(negedge clk);
        b4.cfg_start = 1'b1; b4.in_valid = 1'b0; b4.out_ready = 1'b1;
        #1;
        chk("start_in_ready", b4.in_ready, 0);
        while (!stop && idx < 16) begin
            @(negedge clk);
            b4.cfg_start = 1'b0;
            #1;
            chk("load_busy", b4.cfg_busy, 1);
            chk("load_cfg_ready", b4.cfg_ready, 1);
            chk("load_done", b4.cfg_done, 0);
            chk("load_out_valid", b4.out_valid, 0);
            busy++;
            b4.in_valid  = $urandom % 2 == 1;
            b4.in_vec    = 4'($urandom);
            b4.cfg_bit   = val[idx];
            b4.cfg_valid = gaps ? (($urandom % 4) != 0) : 1'b1;
            if (kind != 0 && idx == at) begin
                stop = 1'b1;
                if (kind == 3) begin
                    rst_n = 1'b0; b4.cfg_valid = 1'b0;
                end else begin
                    b4.cfg_abort = 1'b1; b4.cfg_valid = (kind == 2);
                end
            end else if (b4.cfg_valid) begin
                idx++;
            end
            #1;
            chk("load_in_ready", b4.in_ready, 0);
            if (busy > 200) begin
                n_checks++; n_fail++;
                $error("FAIL load_timeout: observed %0d beats expected 16", idx);
                stop = 1'b1;
            end
        end
        @(negedge clk);
        b4.cfg_valid = 1'b0; b4.cfg_abort = 1'b0; b4.in_valid = 1'b0;
        #1;
        chk("end_busy", b4.cfg_busy, 0);
        if (kind == 3) begin
            chk("rst_out_valid", b4.out_valid, 0);
            chk("rst_out_bit", b4.out_bit, 0);
            chk("rst_out_vec", b4.out_vec, 0);
            chk("rst_cfg_done", b4.cfg_done, 0);
            rst_n = 1'b1;
            ref4 = c_INIT4;
            q_bit.delete(); q_vec.delete();
        end else begin
            chk("cfg_done", b4.cfg_done, kind == 0);
            if (kind == 0) ref4 = val;
            if (kind == 0 && !gaps) chk("busy_cycles", busy, 16);
        end
        @(negedge clk);
        #1;
        chk("done_pulse", b4.cfg_done, 0);
    endtask

    task automatic stream2(input bit inv);
        int p;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            b2.in_valid = (i < 4); b2.in_vec = 2'(i); b2.out_ready = 1'b1;
            #1;
            if (i > 0) begin
                p = i - 1;
                chk("n2_out_valid", b2.out_valid, 1);
                chk("n2_out_bit", b2.out_bit, (((p >> 1) ^ p) & 1) ^ int'(inv));
                chk("n2_out_vec", b2.out_vec, p);
            end
        end
        b2.in_valid = 1'b0;
    endtask

    initial begin
        int busy2;
        logic [3:0] xnor_tab;
        b4.in_valid = 0; b4.in_vec = '0; b4.out_ready = 0; b4.cfg_start = 0;
        b4.cfg_abort = 0; b4.cfg_valid = 0; b4.cfg_bit = 0;
        b2.in_valid = 0; b2.in_vec = '0; b2.out_ready = 0; b2.cfg_start = 0;
        b2.cfg_abort = 0; b2.cfg_valid = 0; b2.cfg_bit = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", b4.out_valid, 0);
        chk("reset_out_bit", b4.out_bit, 0);
        chk("reset_out_vec", b4.out_vec, 0);
        chk("reset_busy", b4.cfg_busy, 0);
        chk("reset_done", b4.cfg_done, 0);
        chk("reset_cfg_ready", b4.cfg_ready, 0);
        rst_n = 1'b1;

        stream4(16, 1'b0);

        // Backpressure with vector 13, then start a load while the result is held.
        @(negedge clk);
        b4.in_valid = 1'b1; b4.in_vec = 4'd13; b4.out_ready = 1'b0;
        #1;
        chk("bp_first_ready", b4.in_ready, 1);
        q_bit.push_back(ref4[13]); q_vec.push_back(4'd13);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("bp_in_ready", b4.in_ready, 0);
            chk("bp_out_valid", b4.out_valid, 1);
            chk("bp_out_bit", b4.out_bit, 1);
            chk("bp_out_vec", b4.out_vec, 13);
        end
        @(negedge clk);
        b4.in_valid = 1'b0; b4.cfg_start = 1'b1;
        #1;
        chk("drain_start_ready", b4.in_ready, 0);
        @(negedge clk);
        b4.cfg_start = 1'b0;
        #1;
        chk("drain_cfg_ready", b4.cfg_ready, 0);
        chk("drain_busy", b4.cfg_busy, 0);
        chk("drain_out_valid", b4.out_valid, 1);
        chk("drain_out_bit", b4.out_bit, q_bit[0]);
        chk("drain_in_ready", b4.in_ready, 0);
        b4.out_ready = 1'b1;
        void'(q_bit.pop_front()); void'(q_vec.pop_front());
        @(negedge clk);
        #1;
        chk("drain_load_busy", b4.cfg_busy, 1);
        chk("drain_load_ready", b4.cfg_ready, 1);
        chk("drain_load_out_valid", b4.out_valid, 0);
        b4.cfg_abort = 1'b1;
        @(negedge clk);
        b4.cfg_abort = 1'b0;
        #1;
        chk("abort_busy", b4.cfg_busy, 0);
        chk("abort_done", b4.cfg_done, 0);
        stream4(16, 1'b0);

        load4(16'hFFFF, 1, 7, 1'b0);
        stream4(16, 1'b0);
        load4(16'hFFFF, 2, 15, 1'b0);
        stream4(16, 1'b0);

        load4(16'h8001, 0, 0, 1'b0);
        stream4(16, 1'b0);
        load4(16'($urandom), 0, 0, 1'b1);
        stream4(60, 1'b1);

        load4(16'h00FF, 3, 10, 1'b0);
        stream4(16, 1'b0);

        // Two-input instance: XOR out of reset, XNOR after a 4-bit reload.
        stream2(1'b0);
        xnor_tab = 4'b1001;
        @(negedge clk);
        b2.cfg_start = 1'b1;
        @(negedge clk);
        b2.cfg_start = 1'b0;
        busy2 = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (b2.cfg_busy) busy2++;
            b2.cfg_valid = 1'b1; b2.cfg_bit = xnor_tab[k];
            @(negedge clk);
        end
        b2.cfg_valid = 1'b0;
        #1;
        chk("n2_busy_cycles", busy2, 4);
        chk("n2_busy_end", b2.cfg_busy, 0);
        chk("n2_cfg_done", b2.cfg_done, 1);
        stream2(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
